// File: rtl/simplez_core.sv
// Simplez accumulator core: multi-cycle FETCH/DECODE/OPER/HALT machine.
// Memory-mapped output and input ports complete without waiting on memory.
module simplez_core #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9,
  parameter logic [ADDRW-1:0] OUT_ADDR = 9'o100,
  parameter logic [ADDRW-1:0] IN_ADDR = 9'o101
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata,
  input  logic             mem_ready,
  input  logic [DATAW-1:0] in_port,
  output logic [DATAW-1:0] out_port,
  output logic             stop
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [ADDRW-1:0] PC_ONE = 1;
  localparam logic [DATAW-1:0] AC_ONE = 1;

  state_t           state;
  logic [ADDRW-1:0] pc;
  logic [DATAW-1:0] ac;
  logic [DATAW-1:0] ri;

  logic [2:0]       co;
  logic [ADDRW-1:0] cd;
  logic             is_ld;
  logic             is_add;
  logic             is_st;
  logic             out_hit;
  logic             in_hit;
  logic [DATAW-1:0] operand;

  // Bits between CO and CD carry no meaning.
  logic [DATAW-1:0] unused_ri;
  assign unused_ri = ri;

  assign co = ri[DATAW-1 -: 3];
  assign cd = ri[ADDRW-1:0];

  assign is_ld  = (co == OP_LD);
  assign is_add = (co == OP_ADD);
  assign is_st  = (co == OP_ST);

  assign out_hit = is_st && (cd == OUT_ADDR);
  assign in_hit  = (is_ld || is_add) && (cd == IN_ADDR);
  assign operand = in_hit ? in_port : mem_rdata;

  assign mem_wdata = ac;
  assign stop      = (state == S_HALT) && !rst;

  // Memory strobes follow the state; reset silences them at once.
  always_comb begin
    mem_addr = pc;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if (state == S_OPER) begin
      mem_addr = cd;
    end
    if (!rst) begin
      unique case (state)
        S_FETCH: mem_re = 1'b1;
        S_OPER: begin
          mem_re = (is_ld || is_add) && !in_hit;
          mem_we = is_st && !out_hit;
        end
        default: begin
          mem_re = 1'b0;
          mem_we = 1'b0;
        end
      endcase
    end
  end

  // Architectural state and sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ac       <= '0;
      ri       <= '0;
      out_port <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ri    <= mem_rdata;
            pc    <= pc + PC_ONE;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (co)
            OP_BR: begin
              pc    <= cd;
              state <= S_FETCH;
            end
            OP_BZ: begin
              if (ac == '0) pc <= cd;
              state <= S_FETCH;
            end
            OP_CLR: begin
              ac    <= '0;
              state <= S_FETCH;
            end
            OP_DEC: begin
              ac    <= ac - AC_ONE;
              state <= S_FETCH;
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_OPER;
          endcase
        end
        S_OPER: begin
          unique case (1'b1)
            out_hit: begin
              out_port <= ac;
              state    <= S_FETCH;
            end
            in_hit: begin
              ac    <= is_ld ? operand : ac + operand;
              state <= S_FETCH;
            end
            default: begin
              if (mem_ready) begin
                if (is_ld) ac <= operand;
                if (is_add) ac <= ac + operand;
                state <= S_FETCH;
              end
            end
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_core.sv
// Directed bench for simplez_core with a 512-word memory model.
// Each scenario loads a program, resets the core and checks ports.
module tb_simplez_core;

  logic        clk;
  logic        rst;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        mem_ready;
  logic [11:0] in_port;
  logic [11:0] out_port;
  logic        stop;

  logic [11:0] mem [512];

  int checks;
  int errors;
  int we_out_cnt;
  int re_in_cnt;
  int both_cnt;

  simplez_core dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .in_port   (in_port),
    .out_port  (out_port),
    .stop      (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Memory write port and strobe monitors.
  always @(posedge clk) begin
    if (mem_we && mem_addr == 9'o100) we_out_cnt++;
    if (mem_re && mem_addr == 9'o101) re_in_cnt++;
    if (mem_re && mem_we) both_cnt++;
    if (mem_we && mem_ready) mem[mem_addr] = mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 12'o0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    we_out_cnt = 0;
    re_in_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic run_to_stop(input string tag, input int limit);
    int n;
    n = 0;
    while (!stop && n < limit) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, stop}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    both_cnt = 0;
    we_out_cnt = 0;
    re_in_cnt = 0;
    rst = 1'b1;
    mem_ready = 1'b1;
    in_port = 12'o0;

    // Scenario: LD / ADD / ST / HALT with timing
    clear_mem();
    mem[0] = 12'o1020;
    mem[1] = 12'o2021;
    mem[2] = 12'o0022;
    mem[3] = 12'o7000;
    mem[9'o20] = 12'd5;
    mem[9'o21] = 12'd7;
    tick();
    tick();
    chk("rst_re", {31'b0, mem_re}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_stop", {31'b0, stop}, 32'd0);
    chk("rst_out", {20'b0, out_port}, 32'd0);
    chk("rst_ac", {20'b0, mem_wdata}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_fetch_addr", {23'b0, mem_addr}, 32'd0);
    chk("first_fetch_re", {31'b0, mem_re}, 32'd1);
    repeat (10) tick();
    chk("s1_stop_at10", {31'b0, stop}, 32'd0);
    tick();
    chk("s1_stop_at11", {31'b0, stop}, 32'd1);
    chk("s1_mem22", {20'b0, mem[9'o22]}, 32'd12);
    chk("s1_ac", {20'b0, mem_wdata}, 32'd12);
    chk("s1_halt_re", {31'b0, mem_re}, 32'd0);
    tick();
    chk("s1_halt_hold", {31'b0, stop}, 32'd1);

    // Scenario: CLR / DEC wrap / ST to output / ST to input address
    clear_mem();
    mem[0] = 12'o5000;
    mem[1] = 12'o6000;
    mem[2] = 12'o0100;
    mem[3] = 12'o0101;
    mem[4] = 12'o7000;
    mem[9'o100] = 12'o1234;
    do_reset();
    run_to_stop("s2_stop", 40);
    chk("s2_out", {20'b0, out_port}, 32'o7777);
    chk("s2_ac", {20'b0, mem_wdata}, 32'o7777);
    chk("s2_no_we_out", we_out_cnt, 0);
    chk("s2_mem100", {20'b0, mem[9'o100]}, 32'o1234);
    chk("s2_mem101", {20'b0, mem[9'o101]}, 32'o7777);

    // Scenario: LD from input port, BZ not taken / taken
    clear_mem();
    mem[0] = 12'o1101;
    mem[1] = 12'o4010;
    mem[2] = 12'o0100;
    mem[3] = 12'o7000;
    mem[9'o10] = 12'o7000;
    mem[9'o101] = 12'o0777;
    in_port = 12'o0042;
    do_reset();
    run_to_stop("s3a_stop", 40);
    chk("s3a_out", {20'b0, out_port}, 32'o42);
    chk("s3a_ac", {20'b0, mem_wdata}, 32'o42);
    chk("s3a_no_re_in", re_in_cnt, 0);
    in_port = 12'o0;
    do_reset();
    repeat (5) tick();
    chk("s3b_bz_addr", {23'b0, mem_addr}, 32'o10);
    chk("s3b_bz_re", {31'b0, mem_re}, 32'd1);
    run_to_stop("s3b_stop", 40);
    chk("s3b_out", {20'b0, out_port}, 32'd0);

    // Scenario: LD with three wait cycles per access
    clear_mem();
    mem[0] = 12'o1020;
    mem[1] = 12'o7000;
    mem[9'o20] = 12'o3456;
    do_reset();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("s4_fw_re", {31'b0, mem_re}, 32'd1);
      chk("s4_fw_addr", {23'b0, mem_addr}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    chk("s4_dec_re", {31'b0, mem_re}, 32'd0);
    chk("s4_dec_we", {31'b0, mem_we}, 32'd0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s4_ow_re", {31'b0, mem_re}, 32'd1);
      chk("s4_ow_addr", {23'b0, mem_addr}, 32'o20);
      chk("s4_ow_ac", {20'b0, mem_wdata}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    chk("s4_ac", {20'b0, mem_wdata}, 32'o3456);
    chk("s4_next_fetch", {23'b0, mem_addr}, 32'd1);
    run_to_stop("s4_stop", 20);

    // Scenario: branch to top of memory and PC wrap
    clear_mem();
    mem[0] = 12'o3777;
    mem[9'o777] = 12'o3000;
    do_reset();
    tick();
    tick();
    chk("s5_f777a", {23'b0, mem_addr}, 32'o777);
    tick();
    tick();
    chk("s5_f0", {23'b0, mem_addr}, 32'd0);
    tick();
    tick();
    chk("s5_f777b", {23'b0, mem_addr}, 32'o777);
    mem[9'o777] = 12'o6000;
    mem[0] = 12'o7000;
    tick();
    tick();
    chk("s5_wrap", {23'b0, mem_addr}, 32'd0);
    run_to_stop("s5_stop", 20);
    chk("s5_ac", {20'b0, mem_wdata}, 32'o7777);

    // Scenario: reset during a stalled ST
    clear_mem();
    mem[0] = 12'o6000;
    mem[1] = 12'o0030;
    mem[2] = 12'o7000;
    mem[9'o30] = 12'o1111;
    do_reset();
    repeat (4) tick();
    mem_ready = 1'b0;
    #1;
    chk("s6_we_pend", {31'b0, mem_we}, 32'd1);
    chk("s6_addr_pend", {23'b0, mem_addr}, 32'o30);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("s6_we_forced", {31'b0, mem_we}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("s6_mem30", {20'b0, mem[9'o30]}, 32'o1111);
    chk("s6_out", {20'b0, out_port}, 32'd0);
    chk("s6_refetch", {23'b0, mem_addr}, 32'd0);
    chk("s6_refetch_re", {31'b0, mem_re}, 32'd1);
    chk("s6_ac", {20'b0, mem_wdata}, 32'd0);

    chk("no_re_we_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
